// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding, counter width,
// and two's-complement helpers sized one bit wider than the operands so |MIN| is representable.
package divider_pkg;

  localparam int DIV_WIDTH = 64;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic logic [DIV_WIDTH:0] abs_ext(input logic [DIV_WIDTH-1:0] v);
    logic [DIV_WIDTH:0] ext;
    ext = {v[DIV_WIDTH-1], v};
    return v[DIV_WIDTH-1] ? (~ext + (DIV_WIDTH+1)'(1)) : ext;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] v);
    return ~v + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor magnitude, keep the difference when non-negative. Combinational.
module div_restoring_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] rem_i,
  input  logic           dbit_i,
  input  logic [WIDTH:0] dvs_i,
  output logic [WIDTH:0] rem_o,
  output logic           q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_rem_msb;

  // The partial remainder is always below |divisor| <= 2^(WIDTH-1), so its top bit is never set.
  assign unused_rem_msb = rem_i[WIDTH];
  assign shifted        = {rem_i[WIDTH-1:0], dbit_i};
  assign trial          = {1'b0, shifted} - {1'b0, dvs_i};
  assign q_bit_o        = ~trial[WIDTH+1];
  assign rem_o          = q_bit_o ? trial[WIDTH:0] : shifted;

endmodule

// File: rtl/booth_divider_64_signed.sv
// Signed divider, one quotient bit per cycle; result T+WIDTH+3 after accept (T+2 for /0 and MIN/-1).
// out_valid holds under back-pressure; in_ready only in IDLE. DIV_EARLY_OUT_EN skips CALC when |a|<|b|.
module booth_divider_64_signed
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_q, b_q, dvd_q;
  logic [WIDTH:0]   dvs_q, rem_q, rem_nxt, a_mag, b_mag;
  logic             sign_q, sign_r, q_bit;
  logic             unused_a_msb;

  assign a_mag        = abs_ext(a_q);
  assign b_mag        = abs_ext(b_q);
  assign unused_a_msb = a_mag[WIDTH];
  assign in_ready     = (state == ST_IDLE);
  assign out_valid    = (state == ST_DONE);

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .dbit_i  (dvd_q[WIDTH-1]),
    .dvs_i   (dvs_q),
    .rem_o   (rem_nxt),
    .q_bit_o (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= dividend_i;
            b_q   <= divisor_i;
            state <= ST_PREP;
          end
        end
        ST_PREP: begin
          sign_q     <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          sign_r     <= a_q[WIDTH-1];
          dvd_q      <= a_mag[WIDTH-1:0];
          dvs_q      <= b_mag;
          rem_q      <= '0;
          count      <= CNT_W'(WIDTH);
          div_zero_o <= 1'b0;
          overflow_o <= 1'b0;
          if (b_q == '0) begin
            quotient_o  <= '1;
            remainder_o <= a_q;
            div_zero_o  <= 1'b1;
            state       <= ST_DONE;
          end else if (a_q == MIN_VAL && b_q == '1) begin
            quotient_o  <= MIN_VAL;
            remainder_o <= '0;
            overflow_o  <= 1'b1;
            state       <= ST_DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            dvd_q <= '0;
            rem_q <= a_mag;
            state <= ST_FIX;
          end
`endif
          else begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          // Quotient bits shift in at the bottom as dividend bits leave from the top.
          rem_q <= rem_nxt;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          quotient_o  <= sign_q ? negate(dvd_q) : dvd_q;
          remainder_o <= sign_r ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider_64_signed.sv
// Bench for booth_divider_64_signed: arithmetic reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_booth_divider_64_signed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend_i = '0;
  logic [63:0] divisor_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient_o, remainder_o;
  logic        div_zero_o, overflow_o;

  int checks = 0;
  int failures = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  booth_divider_64_signed #(.WIDTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } res_t;

  // Reference: plain signed arithmetic (SV '/' truncates toward zero, '%' follows the dividend).
  function automatic res_t ref_div(input logic signed [63:0] a, input logic signed [63:0] b);
    res_t o;
    logic signed [64:0] ma, mb;
    o.dz = 1'b0; o.ov = 1'b0; o.lat = 67; o.q = '0; o.r = '0;
    if (b == 0) begin
      o.q = '1; o.r = a; o.dz = 1'b1; o.lat = 2;
    end else if (a == MIN64 && b == -64'sd1) begin
      o.q = MIN64; o.r = '0; o.ov = 1'b1; o.lat = 2;
    end else begin
      o.q = a / b;
      o.r = a % b;
      ma = a; mb = b;
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (EARLY && ma < mb) o.lat = 3;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Model state: one operation outstanding at a time.
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   busy = 1'b0;
  bit   chk_en = 1'b0;
  res_t exp_r;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      busy = 1'b0;
    end else if (busy && out_ready && (cyc - acc_cyc >= exp_r.lat)) begin
      busy = 1'b0;
    end else if (!busy && in_valid) begin
      busy    = 1'b1;
      acc_cyc = cyc;
      exp_r   = ref_div(dividend_i, divisor_i);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = busy && (cyc + 1 - acc_cyc >= exp_r.lat);
      check("in_ready", 64'(in_ready), 64'(!busy));
      check("out_valid", 64'(out_valid), 64'(ev));
      if (ev && out_valid) begin
        check("model_quotient", quotient_o, exp_r.q);
        check("model_remainder", remainder_o, exp_r.r);
        check("model_div_zero", 64'(div_zero_o), 64'(exp_r.dz));
        check("model_overflow", 64'(overflow_o), 64'(exp_r.ov));
      end
    end
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit lit,
                        input logic [63:0] eq, input logic [63:0] er,
                        input logic edz, input logic eov, input int hold);
    int n;
    @(posedge clk); #1;
    dividend_i = a; divisor_i = b; in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check("accept_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check("result_wait", 64'(out_valid), 64'd1);
    if (lit) begin
      check("lit_quotient", quotient_o, eq);
      check("lit_remainder", remainder_o, er);
      check("lit_div_zero", 64'(div_zero_o), 64'(edz));
      check("lit_overflow", 64'(overflow_o), 64'(eov));
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      dividend_i = 64'd77; divisor_i = 64'd5; in_valid = 1'b1;
      repeat (hold - 1) @(posedge clk);
      #1;
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_quotient", quotient_o, eq);
      check("hold_remainder", remainder_o, er);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("after_handshake_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_quotient", quotient_o, 64'd0);
    check("reset_remainder", remainder_o, 64'd0);
    check("reset_flags", {62'd0, div_zero_o, overflow_o}, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op(64'd100, 64'd7, 1, 64'd14, 64'd2, 0, 0, 0);
    run_op(-64'sd100, 64'd7, 1, -64'sd14, -64'sd2, 0, 0, 0);
    run_op(64'd100, -64'sd7, 1, -64'sd14, 64'd2, 0, 0, 0);
    run_op(-64'sd100, -64'sd7, 1, 64'd14, -64'sd2, 0, 0, 0);
    run_op(64'h1234, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 0, 0);
    run_op(MIN64, -64'sd1, 1, MIN64, 64'd0, 0, 1, 0);
    run_op(MIN64, 64'd1, 1, MIN64, 64'd0, 0, 0, 0);
    run_op(-64'sd7, 64'd2, 1, -64'sd3, -64'sd1, 0, 0, 0);
    run_op(64'd0, 64'd5, 1, 64'd0, 64'd0, 0, 0, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, MIN64, 1, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0);
    run_op(64'd3, 64'd100, 1, 64'd0, 64'd3, 0, 0, 0);
    run_op(-64'sd3, 64'd100, 1, 64'd0, -64'sd3, 0, 0, 0);
    run_op(64'd1000, 64'd10, 1, 64'd100, 64'd0, 0, 0, 10);

    // Abort an operation mid-flight; no result may appear.
    @(posedge clk); #1;
    dividend_i = 64'd12345; divisor_i = 64'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    run_op(64'd5, 64'd3, 1, 64'd1, 64'd2, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = {$urandom, $urandom};
        1: rb = 64'($signed({$urandom, $urandom}) >>> $urandom_range(1, 62));
        2: rb = ($urandom_range(0, 1) != 0) ? -64'($urandom_range(1, 1000)) : 64'($urandom_range(1, 1000));
        default: begin
          ra = 64'($signed(ra) >>> $urandom_range(20, 60));
          rb = {$urandom, $urandom};
        end
      endcase
      run_op(ra, rb, 0, '0, '0, 0, 0, 0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
